// File: rtl/imem_stream_loader.sv
// Byte-stream instruction memory loader: parses a length header, writes big-endian
// words from address 0 while the CPU is held in reset, and releases it on a good XOR checksum.
module imem_stream_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);
    localparam int MAX_WORDS = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {HDR_HI, HDR_LO, PAYLOAD, CHECK, RUN, ERR} state_t;

    state_t          state;
    logic [7:0]      n_hi;
    logic [ADDR_W:0] n_words;
    logic [ADDR_W:0] word_idx;
    logic [1:0]      byte_cnt;
    logic [23:0]     word_sr;
    logic [7:0]      csum;
    logic            accept;
    logic [15:0]     n_full;

    assign accept = in_valid & in_ready;
    assign n_full = {n_hi, in_data};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= HDR_HI;
            n_hi       <= '0;
            n_words    <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            word_sr    <= '0;
            csum       <= '0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            // Terminal transitions below override this with 0 at the same edge.
            if (state != RUN && state != ERR)
                in_ready <= 1'b1;

            if (accept) begin
                case (state)
                    HDR_HI: begin
                        n_hi  <= in_data;
                        csum  <= csum ^ in_data;
                        state <= HDR_LO;
                    end
                    HDR_LO: begin
                        csum <= csum ^ in_data;
                        if (n_full > 16'(MAX_WORDS)) begin
                            state    <= ERR;
                            error    <= 1'b1;
                            in_ready <= 1'b0;
                        end else if (n_full == 16'd0) begin
                            state <= CHECK;
                        end else begin
                            n_words <= n_full[ADDR_W:0];
                            state   <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        csum     <= csum ^ in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= word_idx[ADDR_W-1:0];
                            imem_wdata <= {word_sr, in_data};
                            word_idx   <= word_idx + ONE;
                            if (word_idx == n_words - ONE)
                                state <= CHECK;
                        end else begin
                            word_sr <= {word_sr[15:0], in_data};
                        end
                    end
                    CHECK: begin
                        in_ready <= 1'b0;
                        if (csum == in_data) begin
                            state     <= RUN;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_stream_loader.sv
// Randomized scoreboard bench for imem_stream_loader: expected writes come from the
// program word list, a forked monitor pops and compares every imem_we pulse.
module tb_imem_stream_loader;
    localparam int ADDR_W    = 6;
    localparam int MAX_WORDS = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;

    always #5 clk = ~clk;

    imem_stream_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] prog[$];
    logic [7:0]  stream[$];
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
        else
            $display("ok   %s = %h", name, act);
    endtask

    // Reference model: stream = N_hi, N_lo, words MSB first, XOR of all previous bytes.
    task automatic make_stream(input bit bad, input bit push_exp);
        int         n;
        logic [7:0] x;
        logic [31:0] w;
        n = prog.size();
        stream.delete();
        stream.push_back(8'((n >> 8) & 255));
        stream.push_back(8'(n & 255));
        for (int i = 0; i < n; i++) begin
            w = prog[i];
            for (int k = 3; k >= 0; k--)
                stream.push_back(8'((w >> (8 * k)) & 32'hFF));
            if (push_exp)
                exp_q.push_back('{addr: ADDR_W'(i), data: prog[i]});
        end
        x = 8'h00;
        foreach (stream[i]) x = x ^ stream[i];
        stream.push_back(bad ? (x ^ 8'h01) : x);
    endtask

    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        for (int c = 0; ; c++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                return;
            end
            if (c > 200) begin
                vectors++;
                miscompares++;
                $display("FAIL send_timeout: byte %h not accepted, in_ready=%b", b, in_ready);
                in_valid = 1'b0;
                return;
            end
        end
    endtask

    task automatic send_range(input int first, input int last, input int max_gap);
        for (int i = first; i <= last; i++) begin
            if (max_gap > 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(max_gap, 1)) @(posedge clk);
                #1;
            end
            send_byte(stream[i]);
        end
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_imem_we", 32'(imem_we), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr), 32'd0);
        chk("rst_imem_wdata", imem_wdata, 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Sampled at the negedge right after the checksum-accepting edge.
    task automatic check_end(input string tag, input bit exp_done);
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
        chk({tag, "_error"}, 32'(error), 32'(!exp_done));
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(!exp_done));
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic load_scenario1();
        prog.delete();
        prog.push_back(32'h20080005);
        prog.push_back(32'h20090003);
        prog.push_back(32'h01095020);
    endtask

    initial begin
        wr_t e;
        int  n;
        bit  bad;
        int  gap;
        fork
            forever begin
                @(negedge clk);
                if (reset && imem_we) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_write: addr %h data %h, expected none", imem_addr, imem_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_addr", 32'(imem_addr), 32'(e.addr));
                        chk("wr_data", imem_wdata, e.data);
                    end
                end
            end
        join_none

        // 1: good 3-word load, continuous valid
        do_reset();
        load_scenario1();
        make_stream(1'b0, 1'b1);
        chk("s1_checksum_byte", 32'(stream[stream.size()-1]), 32'h7C);
        send_range(0, stream.size() - 1, 0);
        check_end("s1", 1'b1);

        // 2: bad checksum
        do_reset();
        make_stream(1'b1, 1'b1);
        send_range(0, stream.size() - 1, 0);
        check_end("s2", 1'b0);
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        chk("s2_stays_error", 32'({error, in_ready, cpu_reset}), 32'b101);

        // 3: empty program
        do_reset();
        prog.delete();
        make_stream(1'b0, 1'b1);
        send_range(0, stream.size() - 1, 0);
        check_end("s3", 1'b1);

        // 4: oversize header (MAX_WORDS+1), nothing after it may be taken
        do_reset();
        send_byte(8'h00);
        send_byte(8'(MAX_WORDS + 1));
        check_end("s4", 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h20;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (in_ready) n++;
        end
        in_valid = 1'b0;
        chk("s4_ready_cycles", 32'(n), 32'd0);

        // 5: throttled source
        do_reset();
        load_scenario1();
        make_stream(1'b0, 1'b1);
        send_range(0, stream.size() - 1, 3);
        check_end("s5", 1'b1);

        // 6: reset after six payload bytes, then a full reload
        do_reset();
        make_stream(1'b0, 1'b0);
        exp_q.push_back('{addr: '0, data: prog[0]});
        send_range(0, 7, 0);
        @(negedge clk);
        chk("s6_partial_pending", 32'(exp_q.size()), 32'd0);
        do_reset();
        make_stream(1'b0, 1'b1);
        send_range(0, stream.size() - 1, 0);
        check_end("s6", 1'b1);

        // Random programs including the full-memory boundary
        for (int t = 0; t < 6; t++) begin
            do_reset();
            n   = (t == 0) ? MAX_WORDS : $urandom_range(MAX_WORDS, 1);
            bad = (t != 0) && ($urandom_range(1, 0) == 1);
            gap = $urandom_range(3, 0);
            prog.delete();
            for (int i = 0; i < n; i++) prog.push_back($urandom);
            make_stream(bad, 1'b1);
            send_range(0, stream.size() - 1, gap);
            check_end("rnd", !bad);
        end

        // Header with a nonzero high byte is oversize too
        do_reset();
        send_byte(8'h01);
        send_byte(8'h00);
        check_end("hi_oversize", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, miscompares=%0d", miscompares);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Writer side of the instruction memory the processor fetches from.
- Receives a byte stream over a valid/ready interface: header, program words, checksum.
- Writes the words into instruction memory starting at word address 0, holding the processor in reset throughout.
- Releases the processor only after a good checksum; flags an error and keeps it in reset otherwise.

Parameters:
- ADDR_W, 6, imem word-address width; capacity MAX_WORDS = 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data holds a byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- imem_we  output  1  instruction memory write strobe, one-cycle pulse.
- imem_addr  output  ADDR_W  word address of the write.
- imem_wdata  output  32  instruction word.
- cpu_reset  output  1  active-high reset to the processor.
- done  output  1  program loaded, checksum good.
- error  output  1  load failed.

Behaviour:
- Clock and reset: one clock. reset is asynchronous, active-low.
- Reset values (while reset=0):
  - in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_reset=1, done=0, error=0.
  - state=HDR_HI; byte count, word count and checksum accumulator cleared.
- in_ready is registered. It goes to 1 on the first rising edge after reset deasserts and stays 1 in states HDR_HI, HDR_LO, PAYLOAD and CHECK.
- Handshake: a byte is accepted at a rising edge with in_valid=1 and in_ready=1. in_data is ignored otherwise. in_valid gaps of any length are legal.
- Stream format: N[15:8], N[7:0], then 4*N payload bytes, then 1 checksum byte.
  - Payload words are big-endian: the first byte goes to [31:24].
  - Checksum = XOR of every byte before it, header included.
- States:
  - HDR_HI: accept byte as N[15:8] -> HDR_LO.
  - HDR_LO: accept byte as N[7:0].
    - If N > MAX_WORDS -> ERR.
    - If N == 0 -> CHECK.
    - Else -> PAYLOAD.
  - PAYLOAD: shift bytes into the word register.
    - On the 4th byte of a word, the next cycle has imem_we=1 with imem_addr = word index and imem_wdata = assembled word, for exactly one cycle.
    - The word index then increments.
    - After word N-1's 4th byte -> CHECK.
    - in_ready stays 1, so back-to-back words are written on consecutive 4-byte boundaries.
  - CHECK: accept the checksum byte.
    - Match -> RUN: done=1, cpu_reset=0, registered at the same edge.
    - Mismatch -> ERR: error=1, cpu_reset remains 1.
  - RUN and ERR are terminal: in_ready=0, imem_we=0. Only reset exits them.
- Address width: imem_addr uses the low ADDR_W bits of the word index. No wrap occurs, because N <= MAX_WORDS is enforced.
- N == MAX_WORDS is legal and fills the whole memory.
- The checksum accumulator updates on every accepted byte before the checksum byte.
- Reset mid-load:
  - All state and outputs return to reset values immediately (asynchronously); a partial word is discarded.
  - Memory words already written are not undone.
  - The next stream loads from address 0.
- Reset during RUN puts the processor back into reset (cpu_reset=1) and requires a new load.

Test Plan:
1. Good 3-word load: stream 00 03 | 20 08 00 05 | 20 09 00 03 | 01 09 50 20 | 7C, in_valid held 1 -> three imem_we pulses, each one cycle after the word's 4th byte.
   - Pulses: addr0=0x20080005, addr1=0x20090003, addr2=0x01095020.
   - done=1 and cpu_reset=0 after the edge accepting 0x7C; error=0; in_ready=0.
2. Bad checksum: same stream ending in 7D -> the same three writes occur, then error=1, done=0, cpu_reset=1, in_ready=0 permanently.
3. Empty program: 00 00 | 00 -> no imem_we pulse; done=1, cpu_reset=0.
4. Oversize header with ADDR_W=6: 00 41 -> error=1 at the edge after the second byte; no writes; remaining bytes not accepted (in_ready=0).
5. Throttled source: scenario 1 with in_valid low for 1-3 random cycles between bytes -> identical write addresses and data, still exactly three pulses; done=1.
6. Reset mid-payload: assert reset after 6 payload bytes (one word written), then replay scenario 1 -> outputs reset while reset is low; after release, exactly three further writes at addr 0,1,2 with scenario 1 data; done=1.
